// File: rtl/alu_mult_div_if.sv
// Operand/result bundle between the EX-stage control and the sequential ALU.
// The master issues start/operands/selector; the slave returns results and status.
interface alu_mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] operador1;
    logic [WIDTH-1:0] operador2;
    logic [3:0]       selector;
    logic [WIDTH-1:0] resultado;
    logic [WIDTH-1:0] hi;
    logic             ZF;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, operador1, operador2, selector,
        input  resultado, hi, ZF, ovf, busy, done
    );

    modport slave (
        input  start, operador1, operador2, selector,
        output resultado, hi, ZF, ovf, busy, done
    );
endinterface

// File: rtl/alu_mult_div.sv
// Sequential MIPS EX-stage ALU: single-cycle logic/arith ops plus iterative
// unsigned shift-add MULT and restoring DIVU producing a HI/LO pair.
module alu_mult_div #(
    parameter int WIDTH      = 32,
    parameter bit SIGNED_SLT = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    alu_mult_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MULT = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_in, b_in;
    logic [WIDTH-1:0] add_r, sub_r, alu_res;
    logic             slt, alu_ovf;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_n, div_q_n;
    logic             last_iter;

    assign a_in = bus.operador1;
    assign b_in = bus.operador2;

    always_comb begin
        add_r = a_in + b_in;
        sub_r = a_in - b_in;
        if (SIGNED_SLT) slt = $signed(a_in) < $signed(b_in);
        else            slt = a_in < b_in;

        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.selector)
            OP_AND: alu_res = a_in & b_in;
            OP_OR:  alu_res = a_in | b_in;
            OP_ADD: begin
                alu_res = add_r;
                alu_ovf = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (add_r[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = sub_r;
                alu_ovf = (a_in[WIDTH-1] != b_in[WIDTH-1]) && (sub_r[WIDTH-1] != a_in[WIDTH-1]);
            end
            OP_SLT: alu_res[0] = slt;
            OP_NOR: alu_res = ~(a_in | b_in);
            default: alu_res = '0;
        endcase
    end

    // MUL: acc_hi accumulates partial products, acc_lo shifts the multiplier out / product LSBs in.
    // DIV: acc_hi is the running remainder, acc_lo shifts the dividend out / quotient bits in.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, b_q} : '0);
        mul_hi_n  = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

        div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ge    = div_trial >= {1'b0, b_q};
        div_rem_n = div_ge ? (div_trial[WIDTH-1:0] - b_q) : div_trial[WIDTH-1:0];
        div_q_n   = {acc_lo_q[WIDTH-2:0], div_ge};

        last_iter = (cnt_q == CW'(WIDTH - 1));
    end

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        hi_d     = hi_q;
        b_d      = b_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.selector)
                        OP_MULT, OP_DIVU: begin
                            if (bus.selector == OP_DIVU && b_in == '0) begin
                                res_d  = '1;
                                hi_d   = a_in;
                                ovf_d  = 1'b0;
                                done_d = 1'b1;
                            end else begin
                                state_d  = (bus.selector == OP_MULT) ? MUL : DIV;
                                b_d      = b_in;
                                acc_hi_d = '0;
                                acc_lo_d = a_in;
                                cnt_d    = '0;
                            end
                        end
                        default: begin
                            res_d  = alu_res;
                            ovf_d  = alu_ovf;
                            done_d = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                acc_hi_d = mul_hi_n;
                acc_lo_d = mul_lo_n;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    res_d   = mul_lo_n;
                    hi_d    = mul_hi_n;
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            DIV: begin
                acc_hi_d = div_rem_n;
                acc_lo_d = div_q_n;
                cnt_d    = cnt_q + 1'b1;
                if (last_iter) begin
                    res_d   = div_q_n;
                    hi_d    = div_rem_n;
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            res_q    <= '0;
            hi_q     <= '0;
            b_q      <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            hi_q     <= hi_d;
            b_q      <= b_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign bus.resultado = res_q;
    assign bus.hi        = hi_q;
    assign bus.ZF        = (res_q == '0);
    assign bus.ovf       = ovf_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
endmodule

// File: tb/tb_alu_mult_div.sv
// Directed-vector bench for alu_mult_div: a signed-SLT 32-bit unit, an
// unsigned-SLT 32-bit unit and an 8-bit unit sharing clock and reset.
module tb_alu_mult_div;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_mult_div_if #(.WIDTH(32)) m_if ();
    alu_mult_div_if #(.WIDTH(32)) u_if ();
    alu_mult_div_if #(.WIDTH(8))  w_if ();

    alu_mult_div #(.WIDTH(32), .SIGNED_SLT(1'b1)) u_main (.clk(clk), .rst_n(rst_n), .bus(m_if));
    alu_mult_div #(.WIDTH(32), .SIGNED_SLT(1'b0)) u_uns  (.clk(clk), .rst_n(rst_n), .bus(u_if));
    alu_mult_div #(.WIDTH(8),  .SIGNED_SLT(1'b1)) u_w8   (.clk(clk), .rst_n(rst_n), .bus(w_if));

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one request on the main unit; returns just after the accepting edge.
    task automatic issue(input logic [3:0] sel, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        m_if.start     = 1'b1;
        m_if.selector  = sel;
        m_if.operador1 = a;
        m_if.operador2 = b;
        @(posedge clk);
        #1;
        m_if.start = 1'b0;
    endtask

    // cycles = edges after the accepting edge at which done is seen, -1 on timeout.
    // With poke set, ADD requests with random operands are thrown at the busy unit.
    task automatic wait_done(input bit poke, output int cycles, output bit both);
        cycles = -1;
        both   = 1'b0;
        for (int k = 0; k <= 100 && cycles < 0; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (poke && (k % 5 == 0)) begin
                    m_if.start     = 1'b1;
                    m_if.selector  = 4'b0010;
                    m_if.operador1 = $urandom();
                    m_if.operador2 = $urandom();
                end else begin
                    m_if.start = 1'b0;
                end
                @(posedge clk);
                #1;
            end
            if (m_if.busy && m_if.done) both = 1'b1;
            if (m_if.done) cycles = k;
        end
        m_if.start = 1'b0;
    endtask

    int cyc;
    bit both;

    initial begin
        m_if.start = 1'b0; m_if.selector = '0; m_if.operador1 = '0; m_if.operador2 = '0;
        u_if.start = 1'b0; u_if.selector = '0; u_if.operador1 = '0; u_if.operador2 = '0;
        w_if.start = 1'b0; w_if.selector = '0; w_if.operador1 = '0; w_if.operador2 = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_res",  m_if.resultado, 0);
        check("rst_hi",   m_if.hi, 0);
        check("rst_zf",   m_if.ZF, 1);
        check("rst_busy", m_if.busy, 0);
        check("rst_done", m_if.done, 0);
        check("rst_ovf",  m_if.ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(4'b0110, 32'd5, 32'd5);
        check("sub_res",  m_if.resultado, 0);
        check("sub_zf",   m_if.ZF, 1);
        check("sub_ovf",  m_if.ovf, 0);
        check("sub_done", m_if.done, 1);

        issue(4'b0111, 32'hFFFF_FFFF, 32'd1);
        check("slt_signed", m_if.resultado, 1);

        issue(4'b0000, 32'hF0F0_1234, 32'h0FF0_FFFF);
        check("and_res", m_if.resultado, 32'h00F0_1234);
        issue(4'b0001, 32'hF0F0_1234, 32'h0FF0_FFFF);
        check("or_res",  m_if.resultado, 32'hFFF0_FFFF);
        issue(4'b1100, 32'hF0F0_1234, 32'h0FF0_FFFF);
        check("nor_res", m_if.resultado, 32'h000F_0000);

        issue(4'b0010, 32'h7FFF_FFFF, 32'h1);
        check("add_res",  m_if.resultado, 32'h8000_0000);
        check("add_ovf",  m_if.ovf, 1);
        check("add_zf",   m_if.ZF, 0);
        check("add_done", m_if.done, 1);
        check("add_busy", m_if.busy, 0);
        @(posedge clk);
        #1;
        check("add_done_pulse", m_if.done, 0);
        check("add_hold",       m_if.resultado, 32'h8000_0000);

        issue(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mul_busy0", m_if.busy, 1);
        check("mul_done0", m_if.done, 0);
        wait_done(1'b1, cyc, both);
        check("mul_lat",  cyc, 32);
        check("mul_both", both, 0);
        check("mul_hi",   m_if.hi, 32'hFFFF_FFFE);
        check("mul_lo",   m_if.resultado, 32'h1);
        check("mul_ovf",  m_if.ovf, 0);
        check("mul_busy", m_if.busy, 0);

        // issued during the MULT done cycle: must be accepted at the next edge
        issue(4'b1001, 32'd100, 32'd7);
        check("div_b2b_busy", m_if.busy, 1);
        wait_done(1'b0, cyc, both);
        check("div_lat", cyc, 32);
        check("div_q",   m_if.resultado, 14);
        check("div_r",   m_if.hi, 2);

        issue(4'b0000, 32'hFFFF_0000, 32'h0F0F_0F0F);
        check("and2_res",  m_if.resultado, 32'h0F0F_0000);
        check("and2_hi_kept", m_if.hi, 2);

        issue(4'b1001, 32'h1234, 32'h0);
        check("div0_q",    m_if.resultado, 32'hFFFF_FFFF);
        check("div0_r",    m_if.hi, 32'h1234);
        check("div0_done", m_if.done, 1);
        check("div0_busy", m_if.busy, 0);
        @(posedge clk);
        #1;
        check("div0_busy_after", m_if.busy, 0);
        check("div0_done_after", m_if.done, 0);

        issue(4'b1000, 32'h0001_2345, 32'h0000_6789);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", m_if.busy, 0);
        check("arst_done", m_if.done, 0);
        check("arst_res",  m_if.resultado, 0);
        check("arst_hi",   m_if.hi, 0);
        check("arst_zf",   m_if.ZF, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'b0010, 32'd2, 32'd3);
        check("post_rst_add",  m_if.resultado, 5);
        check("post_rst_done", m_if.done, 1);

        @(negedge clk);
        u_if.start = 1'b1; u_if.selector = 4'b0111;
        u_if.operador1 = 32'hFFFF_FFFF; u_if.operador2 = 32'd1;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
        check("slt_unsigned", u_if.resultado, 0);
        check("slt_uns_done", u_if.done, 1);

        @(negedge clk);
        w_if.start = 1'b1; w_if.selector = 4'b1000;
        w_if.operador1 = 8'hFF; w_if.operador2 = 8'h02;
        @(posedge clk);
        #1;
        w_if.start = 1'b0;
        cyc = -1;
        for (int k = 0; k <= 50 && cyc < 0; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            if (w_if.done) cyc = k;
        end
        check("w8_mul_lat", cyc, 8);
        check("w8_mul_hi",  w_if.hi, 8'h01);
        check("w8_mul_lo",  w_if.resultado, 8'hFE);

        @(negedge clk);
        w_if.start = 1'b1; w_if.selector = 4'b1111;
        w_if.operador1 = 8'h05; w_if.operador2 = 8'h03;
        @(posedge clk);
        #1;
        w_if.start = 1'b0;
        check("w8_undef_res",  w_if.resultado, 0);
        check("w8_undef_zf",   w_if.ZF, 1);
        check("w8_undef_done", w_if.done, 1);
        check("w8_undef_hi",   w_if.hi, 8'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
